// File: rtl/wb_mem_responder.sv
// Pipelined Wishbone memory responder: word-addressed RAM answered in order after a
// fixed delay line, throttled by an outstanding-request counter.
module wb_mem_responder #(
  parameter int              AW        = 32,
  parameter int              DW        = 32,
  parameter int              LGMEMSZ   = 12,
  parameter logic [AW-1:0]   BASE_ADDR = '0,
  parameter int              LATENCY   = 2,
  parameter int              MAX_OUT   = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wb_stb,
  input  logic              i_wb_we,
  input  logic [AW-1:0]     i_wb_addr,
  input  logic [DW-1:0]     i_wb_data,
  input  logic [DW/8-1:0]   i_wb_be,
  output logic              o_wb_stall,
  output logic              o_wb_ack,
  output logic              o_wb_err,
  output logic [DW-1:0]     o_wb_data,
  output logic              o_busy
);

  localparam int NB     = DW / 8;
  localparam int NWORDS = 2 ** (LGMEMSZ - 2);
  localparam int CW     = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_OUT);
  localparam logic [AW:0]   MEM_BYTES = (AW + 1)'(1) << LGMEMSZ;

  logic [DW-1:0]               mem [NWORDS];
  logic [CW-1:0]               outstanding;
  logic [AW-1:0]               offset;
  logic                        in_range;
  logic                        accept;
  logic                        retire;
  logic [LGMEMSZ-3:0]          word_idx;
  logic [DW-1:0]               rd_word;
  logic [LATENCY-1:0]          pv, pe, v_in, e_in;
  logic [LATENCY-1:0][DW-1:0]  pd, d_in;

  assign offset     = i_wb_addr - BASE_ADDR;
  assign in_range   = {1'b0, offset} < MEM_BYTES;
  assign word_idx   = i_wb_addr[LGMEMSZ-1:2];
  assign o_wb_stall = i_reset && (outstanding == MAX_CNT);
  assign accept     = i_reset && i_wb_stb && !o_wb_stall;
  assign rd_word    = in_range ? mem[word_idx] : '0;

  // Last delay-line stage doubles as the response register; its data only moves on a valid entry
  assign retire     = pv[LATENCY-1];
  assign o_wb_ack   = pv[LATENCY-1] && !pe[LATENCY-1];
  assign o_wb_err   = pv[LATENCY-1] && pe[LATENCY-1];
  assign o_wb_data  = pd[LATENCY-1];
  assign o_busy     = (outstanding != '0);

  generate
    if (LATENCY == 1) begin : g_lat1
      assign v_in = accept;
      assign e_in = !in_range;
      assign d_in = rd_word;
    end else begin : g_latn
      assign v_in = {pv[LATENCY-2:0], accept};
      assign e_in = {pe[LATENCY-2:0], !in_range};
      assign d_in = {pd[LATENCY-2:0], rd_word};
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      pv          <= '0;
      pe          <= '0;
      pd          <= '0;
      outstanding <= '0;
    end else begin
      pv <= v_in;
      pe <= e_in;
      for (int i = 0; i < LATENCY - 1; i++) begin
        pd[i] <= d_in[i];
      end
      if (v_in[LATENCY-1]) begin
        pd[LATENCY-1] <= d_in[LATENCY-1];
      end
      if (accept && !retire) begin
        outstanding <= outstanding + CW'(1);
      end else if (!accept && retire && (outstanding != '0)) begin
        outstanding <= outstanding - CW'(1);
      end
    end
  end

  // RAM contents survive reset; accept is already gated by reset
  always_ff @(posedge i_clk) begin
    if (accept && i_wb_we && in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (i_wb_be[b]) begin
          mem[word_idx][b*8 +: 8] <= i_wb_data[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_mem_responder.sv
// Bench for wb_mem_responder: two instances (LATENCY 2 and 4) checked every cycle
// against a queue-based response model with directed and random requests.
module tb_wb_mem_responder;

  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        rst_n, stb, we, sel;
  logic [31:0] addr, wdata;
  logic [3:0]  be;

  logic        stb2, stall2, ack2, err2, busy2;
  logic        stb4, stall4, ack4, err4, busy4;
  logic [31:0] data2, data4;
  logic        o_stall, o_ack, o_err, o_busy;
  logic [31:0] o_data;

  always #5 clk = ~clk;

  assign stb2    = stb && !sel;
  assign stb4    = stb && sel;
  assign o_stall = sel ? stall4 : stall2;
  assign o_ack   = sel ? ack4   : ack2;
  assign o_err   = sel ? err4   : err2;
  assign o_busy  = sel ? busy4  : busy2;
  assign o_data  = sel ? data4  : data2;

  wb_mem_responder #(.LATENCY(2), .MAX_OUT(MAXO)) u_dut2 (
    .i_clk(clk), .i_reset(rst_n), .i_wb_stb(stb2), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_be(be),
    .o_wb_stall(stall2), .o_wb_ack(ack2), .o_wb_err(err2),
    .o_wb_data(data2), .o_busy(busy2)
  );

  wb_mem_responder #(.LATENCY(4), .MAX_OUT(MAXO)) u_dut4 (
    .i_clk(clk), .i_reset(rst_n), .i_wb_stb(stb4), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_be(be),
    .o_wb_stall(stall4), .o_wb_ack(ack4), .o_wb_err(err4),
    .o_wb_data(data4), .o_busy(busy4)
  );

  typedef struct {
    int          due;
    logic        err;
    logic        is_rd;
    logic [31:0] data;
  } resp_t;

  resp_t       q[$];
  logic [31:0] mm [16];
  int          edge_n = 0;
  int          lat = 2;
  int          total = 0;
  int          bad = 0;
  logic [31:0] held = '0;
  logic        held_known = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h edge=%0d", tag, obs, exp, edge_n);
    end
  endtask

  // One clock: drive at negedge, update model at posedge, compare at next negedge
  task automatic cyc(input logic r, input logic s, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] b, output logic acc);
    logic  exp_stall, exp_ack, exp_err, inr;
    resp_t it;
    rst_n = r; stb = s; we = w; addr = a; wdata = d; be = b;
    exp_stall = r && (q.size() == MAXO);
    #1 check("stall", {31'b0, o_stall}, {31'b0, exp_stall});
    acc = r && s && !exp_stall;
    @(posedge clk);
    edge_n++;
    if (!r) begin
      q.delete();
      held = '0;
      held_known = 1'b1;
    end else if (acc) begin
      inr      = ({1'b0, a} < 33'h1000);
      it.due   = edge_n + lat - 1;
      it.err   = !inr;
      it.is_rd = !w;
      it.data  = inr ? mm[a[5:2]] : 32'h0;
      if (inr && w) begin
        for (int k = 0; k < 4; k++) if (b[k]) mm[a[5:2]][k*8 +: 8] = d[k*8 +: 8];
      end
      q.push_back(it);
    end
    @(negedge clk);
    while (q.size() > 0 && q[0].due < edge_n) void'(q.pop_front());
    exp_ack = 1'b0;
    exp_err = 1'b0;
    if (q.size() > 0 && q[0].due == edge_n) begin
      exp_ack = !q[0].err;
      exp_err = q[0].err;
      if (q[0].err) begin
        held = '0; held_known = 1'b1;
      end else if (q[0].is_rd) begin
        held = q[0].data; held_known = 1'b1;
      end else begin
        held_known = 1'b0;
      end
    end
    check("ack",  {31'b0, o_ack},  {31'b0, exp_ack});
    check("err",  {31'b0, o_err},  {31'b0, exp_err});
    check("busy", {31'b0, o_busy}, {31'b0, (q.size() != 0)});
    if (held_known) check("data", o_data, held);
  endtask

  task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    logic acc;
    int   n = 0;
    do begin
      cyc(1'b1, 1'b1, w, a, d, b, acc);
      n++;
    end while (!acc && n < 40);
    if (!acc) begin
      bad++;
      $error("FAIL req_timeout observed=stalled expected=accept addr=%h", a);
    end
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, acc);
  endtask

  task automatic do_reset(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, acc);
  endtask

  task automatic prefill();
    for (int i = 0; i < 16; i++) req(1'b1, 32'(i * 4), $urandom, 4'hF);
    idle(6);
  endtask

  task automatic random_run(input int n);
    logic        acc, r;
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      r = ($urandom_range(0, 79) != 0);
      case ($urandom_range(0, 7))
        0:       a = 32'h0000_1000 + 32'($urandom_range(0, 255));
        1:       a = 32'hFFFF_FFF0;
        default: a = 32'($urandom_range(0, 63));
      endcase
      cyc(r, ($urandom_range(0, 2) != 0), $urandom_range(0, 1) == 1, a, $urandom,
          4'($urandom_range(0, 15)), acc);
    end
    idle(8);
  endtask

  task automatic directed_common();
    logic acc;
    req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    req(1'b0, 32'h10, 32'h0, 4'h0);
    idle(4);
    req(1'b1, 32'h10, 32'h0000AB00, 4'b0010);
    req(1'b0, 32'h10, 32'h0, 4'h0);
    req(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0);
    req(1'b0, 32'h10, 32'h0, 4'h0);
    idle(6);
    req(1'b1, 32'h1000, 32'hCAFEF00D, 4'hF);
    req(1'b0, 32'h1000, 32'h0, 4'hF);
    req(1'b0, 32'h0, 32'h0, 4'h0);
    idle(6);
    req(1'b1, 32'h20, 32'h11111111, 4'hF);
    req(1'b0, 32'h20, 32'h0, 4'h0);
    idle(6);
    req(1'b0, 32'h4, 32'h0, 4'h0);
    req(1'b0, 32'h8, 32'h0, 4'h0);
    cyc(1'b0, 1'b1, 1'b1, 32'h4, 32'h55555555, 4'hF, acc);
    idle(8);
    req(1'b0, 32'h4, 32'h0, 4'h0);
    req(1'b0, 32'h8, 32'h0, 4'h0);
    idle(6);
  endtask

  initial begin
    sel = 1'b0; rst_n = 1'b0; stb = 1'b0; we = 1'b0;
    addr = '0; wdata = '0; be = '0;
    @(negedge clk);

    lat = 2;
    do_reset(3);
    prefill();
    directed_common();
    random_run(300);

    sel = 1'b1;
    lat = 4;
    do_reset(3);
    prefill();
    req(1'b0, 32'h0, 32'h0, 4'h0);
    req(1'b0, 32'h4, 32'h0, 4'h0);
    req(1'b0, 32'h8, 32'h0, 4'h0);
    idle(8);
    directed_common();
    random_run(300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
